message_stream_arbiter: RTL
===========================

// Module: message_stream_arbiter
// PURPOSE
//  Packet-atomic round-robin arbiter sharing one message output between N_STREAMS input buffers.
//  Each input buffer presents a head word, raises a per-stream full flag when a word is ready, and pops on a one-cycle delete pulse.
//  Message format: word bit WIDTH-1 = 1 marks a header; bits [WIDTH-2 -: LOG_MAX_PACKET_LENGTH] = number of body words that follow.
//  Once a header is granted, every body word of that stream passes before any other stream is served.
// PARAMETERS
//  N_STREAMS             4   number of requesting input buffers
//  LOG_N_STREAMS         2   width of the stream index, ceil(log2(N_STREAMS))
//  WIDTH                 32  message word width
//  LOG_MAX_PACKET_LENGTH 10  width of the header length field
//  TIMEOUT_CYCLES        256 stall limit, used only when MSA_TIMEOUT_EN is defined
//  LOG_TIMEOUT_CYCLES    8   width of the stall counter
// PORTS
//  clk            in   1                clock
//  rst            in   1                synchronous reset, active-high
//  in_data        in   WIDTH*N_STREAMS  head words; stream i occupies [WIDTH*(i+1)-1 -: WIDTH]
//  in_full        in   N_STREAMS        head word of stream i is valid
//  read_deletes   out  N_STREAMS        one-hot pop pulse to the input buffers (registered)
//  out_data       out  WIDTH            forwarded word (registered)
//  out_nd         out  1                out_data valid, 1-cycle pulse
//  out_ready      in   1                downstream accepts a word this cycle
//  grant          out  LOG_N_STREAMS    stream currently owning the output
//  busy           out  1                inside a packet (header sent, body words remaining)
//  error          out  1                1-cycle pulse on a protocol error or timeout
// BEHAVIOUR
//  Reset: all outputs are 0, state SELECT, rr pointer = N_STREAMS-1, remaining count = 0.
//  SELECT
//   - Choose the first stream with in_full set, searching (ptr+1 .. ptr) modulo N_STREAMS.
//   - Load grant and go to HEAD. If no stream has in_full set, stay in SELECT.
//  HEAD
//   - Acts only when in_full[grant] && out_ready; otherwise hold, with all outputs deasserted except grant.
//   - If the word is a header:
//     - Pop it, set out_nd=1 and out_data=word.
//     - remaining <= length field, ptr <= grant.
//     - Length 0: go to GAP, then SELECT. Length nonzero: set busy and go to GAP, then BODY.
//   - If the word is not a header:
//     - Pop it and discard it (out_nd stays 0), pulse error, ptr <= grant.
//     - Go to GAP, then SELECT.
//  BODY
//   - Acts only when in_full[grant] && out_ready.
//   - Pop and forward the word; remaining <= remaining-1.
//   - If remaining was 1: clear busy, go to GAP, then SELECT. Otherwise go to GAP, then BODY.
//   - Body words are forwarded verbatim; bit WIDTH-1 is not inspected.
//  GAP
//   - One idle cycle with read_deletes=0; the buffer needs a cycle to present its new head word.
//   - No two pops to any buffer occur on consecutive cycles.
//  Timing and arbitration
//   - Latency: out_nd and read_deletes assert in the same cycle, one clk after the qualifying cycle.
//   - Peak throughput: 1 word per 2 cycles.
//   - grant and busy never change mid-packet. Other streams asserting in_full during BODY are ignored.
//   - Fairness: ptr advances to the just-served stream. With all streams ready, service order is 0,1,2,3,0...
//   - Arithmetic: remaining is an unsigned LOG_MAX_PACKET_LENGTH-bit counter and never wraps below 0.
//  Reset mid-packet: state returns to SELECT immediately. The rest of the partial packet is later seen as non-header words and is dropped with error pulses.
// CONFIGURATION
//  MSA_TIMEOUT_EN defined:
//   - A stall counter clears on each pop and increments in BODY while in_full[grant] is 0.
//   - When it reaches TIMEOUT_CYCLES-1: pulse error, clear busy and remaining, go to SELECT. The packet is abandoned.
//   - out_ready low does not advance the counter.
//  MSA_TIMEOUT_EN undefined:
//   - No counter is implemented; BODY waits indefinitely for the granted stream.
// TESTING
//  1. Stream 1 sends header 0x80400000 (len 2), then 0x11, 0x22 -> out_data 0x80400000,0x11,0x22 with out_nd spaced 2 cycles apart; grant=1 and busy=1 until the last word.
//  2. All 4 streams each hold a len-0 header -> grants in order 0,1,2,3; one out_nd per stream; no error.
//  3. Stream 0 is mid-packet (len 3) while stream 2 has data -> all 4 stream-0 words are output before any stream-2 word.
//  4. Stream 3 head word is 0x00000005 (no header bit) -> read_deletes=4'b1000, error pulse, out_nd stays 0.
//  5. out_ready held low 10 cycles in BODY -> no pop, no out_nd; transfer resumes the cycle after out_ready rises.
//  6. With MSA_TIMEOUT_EN and TIMEOUT_CYCLES=16: the stream stops after the header of a len-4 packet -> error pulse at stall cycle 16, busy=0, the next stream is granted. Rst asserted mid-packet -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/message_stream_arbiter_if.sv
// rtl/message_stream_arbiter_if.sv - handshake bundle between input buffers, arbiter and downstream sink
//
// Purpose: groups the buffer-side and sink-side signals of message_stream_arbiter.
// Ports (signals):
//   in_data       head words, stream i at [WIDTH*(i+1)-1 -: WIDTH]
//   in_full       per-stream head word valid
//   read_deletes  one-hot pop pulse back to the input buffers
//   out_data      forwarded word
//   out_nd        out_data valid pulse
//   out_ready     downstream accepts a word this cycle
//   grant         stream currently owning the output
//   busy          inside a packet (body words remaining)
//   error         protocol error / timeout pulse
// Modports: master = arbiter side, slave = buffers + sink side.

interface message_stream_arbiter_if #(
    parameter int N_STREAMS     = 4,
    parameter int LOG_N_STREAMS = 2,
    parameter int WIDTH         = 32
);
    logic [WIDTH*N_STREAMS-1:0] in_data;
    logic [N_STREAMS-1:0]       in_full;
    logic [N_STREAMS-1:0]       read_deletes;
    logic [WIDTH-1:0]           out_data;
    logic                       out_nd;
    logic                       out_ready;
    logic [LOG_N_STREAMS-1:0]   grant;
    logic                       busy;
    logic                       error;

    modport master (
        input  in_data, in_full, out_ready,
        output read_deletes, out_data, out_nd, grant, busy, error
    );

    modport slave (
        output in_data, in_full, out_ready,
        input  read_deletes, out_data, out_nd, grant, busy, error
    );
endinterface

// File: rtl/message_stream_arbiter.sv
// rtl/message_stream_arbiter.sv - packet-atomic round-robin arbiter onto one message output
//
// Purpose: shares one registered message output between N_STREAMS input buffers.
//   A header word (bit WIDTH-1 set) carries the body length in
//   [WIDTH-2 -: LOG_MAX_PACKET_LENGTH]; once a header is granted, the whole
//   body of that stream is forwarded before another stream is served.
//   Non-header words at packet start are popped and dropped with an error pulse.
// Ports:
//   clk   clock
//   rst   synchronous reset, active-high
//   bus   message_stream_arbiter_if.master (in_data, in_full, read_deletes,
//         out_data, out_nd, out_ready, grant, busy, error)
// Optional build macro: MSA_TIMEOUT_EN - abandons a packet whose granted stream
//   stays empty for TIMEOUT_CYCLES body cycles.

module message_stream_arbiter #(
    parameter int N_STREAMS             = 4,
    parameter int LOG_N_STREAMS         = 2,
    parameter int WIDTH                 = 32,
    parameter int LOG_MAX_PACKET_LENGTH = 10,
    parameter int TIMEOUT_CYCLES        = 256,
    parameter int LOG_TIMEOUT_CYCLES    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    message_stream_arbiter_if.master bus
);
    localparam logic [1:0] S_SELECT = 2'd0;
    localparam logic [1:0] S_HEAD   = 2'd1;
    localparam logic [1:0] S_BODY   = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    logic [1:0]                       state_q, state_d;
    logic [LOG_N_STREAMS-1:0]         ptr_q, ptr_d;
    logic [LOG_N_STREAMS-1:0]         grant_q, grant_d;
    logic [LOG_MAX_PACKET_LENGTH-1:0] remaining_q, remaining_d;
    logic                             busy_q, busy_d;
    logic                             out_nd_q, out_nd_d;
    logic                             error_q, error_d;
    logic [WIDTH-1:0]                 out_data_q, out_data_d;
    logic [N_STREAMS-1:0]             read_deletes_q, read_deletes_d;

    logic [WIDTH-1:0]                 head_word;
    logic [LOG_MAX_PACKET_LENGTH-1:0] head_len;
    logic                             head_valid;
    logic                             fire;
    logic [N_STREAMS-1:0]             pop_onehot;
    logic                             found;
    logic [LOG_N_STREAMS-1:0]         next_sel;
    logic [LOG_N_STREAMS-1:0]         cand;

`ifdef MSA_TIMEOUT_EN
    logic [LOG_TIMEOUT_CYCLES-1:0]    stall_q, stall_d;
`else
    logic                             unused_timeout_cfg;
    assign unused_timeout_cfg = ^{TIMEOUT_CYCLES[0], LOG_TIMEOUT_CYCLES[0]};
`endif

    assign head_word  = bus.in_data[WIDTH*grant_q +: WIDTH];
    assign head_len   = head_word[WIDTH-2 -: LOG_MAX_PACKET_LENGTH];
    assign head_valid = bus.in_full[grant_q];
    assign fire       = head_valid && bus.out_ready;
    assign pop_onehot = {{(N_STREAMS-1){1'b0}}, 1'b1} << grant_q;

    // Round-robin search starting just after the last served stream.
    always_comb begin
        found    = 1'b0;
        next_sel = ptr_q;
        cand     = '0;
        for (int k = 1; k <= N_STREAMS; k++) begin
            cand = LOG_N_STREAMS'((int'(ptr_q) + k) % N_STREAMS);
            if (!found && bus.in_full[cand]) begin
                found    = 1'b1;
                next_sel = cand;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        grant_d        = grant_q;
        remaining_d    = remaining_q;
        busy_d         = busy_q;
        out_nd_d       = 1'b0;
        out_data_d     = '0;
        error_d        = 1'b0;
        read_deletes_d = '0;
`ifdef MSA_TIMEOUT_EN
        stall_d        = stall_q;
`endif
        case (state_q)
            S_SELECT: begin
                if (found) begin
                    grant_d = next_sel;
                    state_d = S_HEAD;
                end
            end
            S_HEAD: begin
                if (fire) begin
                    read_deletes_d = pop_onehot;
                    ptr_d          = grant_q;
                    state_d        = S_GAP;
                    if (head_word[WIDTH-1]) begin
                        out_nd_d    = 1'b1;
                        out_data_d  = head_word;
                        remaining_d = head_len;
                        busy_d      = (head_len != '0);
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_BODY: begin
                if (fire) begin
                    read_deletes_d = pop_onehot;
                    out_nd_d       = 1'b1;
                    out_data_d     = head_word;
                    state_d        = S_GAP;
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - 1'b1;
                    end
                    if (remaining_q <= LOG_MAX_PACKET_LENGTH'(1)) begin
                        busy_d = 1'b0;
                    end
                end
`ifdef MSA_TIMEOUT_EN
                // Only an empty granted buffer counts as a stall; downstream
                // back-pressure is not the source's fault.
                else if (!head_valid && bus.out_ready) begin
                    if (stall_q == LOG_TIMEOUT_CYCLES'(TIMEOUT_CYCLES - 1)) begin
                        error_d     = 1'b1;
                        busy_d      = 1'b0;
                        remaining_d = '0;
                        stall_d     = '0;
                        state_d     = S_SELECT;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
`endif
            end
            S_GAP: begin
                // Lets the popped buffer present its next head word; busy
                // still set means body words remain.
                state_d = busy_q ? S_BODY : S_SELECT;
            end
            default: state_d = S_SELECT;
        endcase
`ifdef MSA_TIMEOUT_EN
        if (read_deletes_d != '0) begin
            stall_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_SELECT;
            ptr_q          <= LOG_N_STREAMS'(N_STREAMS - 1);
            grant_q        <= '0;
            remaining_q    <= '0;
            busy_q         <= 1'b0;
            out_nd_q       <= 1'b0;
            error_q        <= 1'b0;
            out_data_q     <= '0;
            read_deletes_q <= '0;
`ifdef MSA_TIMEOUT_EN
            stall_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            grant_q        <= grant_d;
            remaining_q    <= remaining_d;
            busy_q         <= busy_d;
            out_nd_q       <= out_nd_d;
            error_q        <= error_d;
            out_data_q     <= out_data_d;
            read_deletes_q <= read_deletes_d;
`ifdef MSA_TIMEOUT_EN
            stall_q        <= stall_d;
`endif
        end
    end

    assign bus.read_deletes = read_deletes_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_nd       = out_nd_q;
    assign bus.grant        = grant_q;
    assign bus.busy         = busy_q;
    assign bus.error        = error_q;
endmodule
